// File: rtl/ysyx_22050612_ifu_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, instruction handoff to execute, commit return.
// Latency: none. This is wiring only.
// Backpressure: imem_req_ready stalls the request, and inst_ready stalls the handoff. The response and commit paths have no backpressure.
interface ysyx_22050612_ifu_fetch_if #(
  parameter int XLEN = 64
);
  // instruction memory request
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  // instruction memory response
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            imem_rsp_err;
  // instruction handoff to execute
  logic            inst_valid;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;
  // commit return from execute
  logic            commit_valid;
  logic [XLEN-1:0] commit_dnpc;

  // fetch side
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    output inst_valid, inst, inst_pc,
    input  inst_ready,
    input  commit_valid, commit_dnpc
  );

  // memory + execute side
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    input  inst_valid, inst, inst_pc,
    output inst_ready,
    output commit_valid, commit_dnpc
  );
endinterface

// File: rtl/ysyx_22050612_ifu_fetch.sv
// Single-issue fetch: owns the PC, fetches one word, hands it to execute and waits for the commit before fetching again.
// Latency: a commit at cycle N gives a request at N+1, and a response at N gives inst_valid at N+1. The minimum is 4 cycles per instruction plus execute time.
// Backpressure: the request holds addr/valid until imem_req_ready, and the instruction holds until inst_ready. Misaligned PCs and access faults park the stage in FAULT.
module ysyx_22050612_ifu_fetch #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 'h0000_0000_8000_0000
) (
  input  logic                          clk,
  input  logic                          rst,
  ysyx_22050612_ifu_fetch_if.master     bus,
  output logic                          fetch_fault,
  output logic [63:0]                   retire_cnt
);

  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_WAIT  = 3'd1,
    S_HOLD  = 3'd2,
    S_EXEC  = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic [63:0]     retire_q, retire_d;
  logic            req_vld_q, req_vld_d;
  logic            inst_vld_q, inst_vld_d;
  logic            fault_q, fault_d;

  // next-state, datapath updates and registered-output decode for the fetch FSM
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    retire_d  = retire_q;

    unique case (state_q)
      S_REQ: begin
        // valid is already high here, so ready alone completes the handshake
        if (bus.imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.imem_rsp_valid) begin
          if (bus.imem_rsp_err) begin
            state_d = S_FAULT;
          end else begin
            state_d   = S_HOLD;
            inst_d    = bus.imem_rsp_data;
            inst_pc_d = pc_q;
          end
        end
      end
      S_HOLD: begin
        // any commit seen here is dropped: execute has not taken the word yet
        if (bus.inst_ready) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (bus.commit_valid) begin
          retire_d = retire_q + 64'd1;
          pc_d     = bus.commit_dnpc;
          // the bad PC is still recorded so it can be inspected after the fault
          state_d  = (bus.commit_dnpc[1:0] == 2'b00) ? S_REQ : S_FAULT;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase

    // outputs are decoded from the next state so they are glitch-free flops
    req_vld_d  = (state_d == S_REQ);
    inst_vld_d = (state_d == S_HOLD);
    fault_d    = (state_d == S_FAULT);
  end

  // state and output registers with synchronous reset back to a fresh fetch at RESET_PC
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      inst_q     <= 32'd0;
      inst_pc_q  <= RESET_PC;
      retire_q   <= 64'd0;
      req_vld_q  <= 1'b1;
      inst_vld_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      retire_q   <= retire_d;
      req_vld_q  <= req_vld_d;
      inst_vld_q <= inst_vld_d;
      fault_q    <= fault_d;
    end
  end

  // valids are masked while reset is held so nothing leaks before the first clean cycle
  assign bus.imem_req_valid = req_vld_q & ~rst;
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = inst_vld_q & ~rst;
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = inst_pc_q;
  assign fetch_fault        = fault_q;
  assign retire_cnt         = retire_q;

endmodule

// File: tb/tb_ysyx_22050612_ifu_fetch.sv
// Bench for the fetch stage: a cycle table for the directed corners, then transaction-level random traffic against a PC-chain model.
// Latency: inputs are driven at the negedge and outputs are sampled 1ns later, away from the active posedge.
// Backpressure: the bench plays both memory and execute, inserting random ready/response/commit delays.
module tb_ysyx_22050612_ifu_fetch;

  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_fault;
  logic [63:0] retire_cnt;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  // reference model: the PC the next fetch must use and the retirements so far
  logic [63:0] m_pc;
  logic [63:0] m_retire;

  ysyx_22050612_ifu_fetch_if #(.XLEN(64)) ifc ();

  ysyx_22050612_ifu_fetch #(.XLEN(64), .RESET_PC(RPC)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (ifc),
    .fetch_fault (fetch_fault),
    .retire_cnt  (retire_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got t=%0t required < 2ms", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    ifc.imem_req_ready = 1'b0;
    ifc.imem_rsp_valid = 1'b0;
    ifc.imem_rsp_data  = 32'd0;
    ifc.imem_rsp_err   = 1'b0;
    ifc.inst_ready     = 1'b0;
    ifc.commit_valid   = 1'b0;
    ifc.commit_dnpc    = 64'd0;
  endtask

  // assert rst for one edge, then release at the negedge and check the fresh REQ state
  task automatic do_reset(input string tag);
    clear_inputs();
    rst = 1'b1;
    #1;
    chk1({tag, "_rst_req_valid"}, ifc.imem_req_valid, 1'b0);
    chk1({tag, "_rst_inst_valid"}, ifc.inst_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1({tag, "_req_valid"}, ifc.imem_req_valid, 1'b1);
    chk64({tag, "_req_addr"}, ifc.imem_req_addr, RPC);
    chk1({tag, "_fault"}, fetch_fault, 1'b0);
    chk64({tag, "_retire"}, retire_cnt, 64'd0);
    chk1({tag, "_inst_valid"}, ifc.inst_valid, 1'b0);
    m_pc     = RPC;
    m_retire = 64'd0;
  endtask

  // one full instruction as memory + execute, with the given stall counts
  task automatic run_one(input int d_req, input int d_rsp, input int d_take, input int d_com,
                         input logic [63:0] dnpc, input logic [31:0] data);
    int n;
    n = 0;
    while (ifc.imem_req_valid !== 1'b1 && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk1("txn_req_valid", ifc.imem_req_valid, 1'b1);
    chk64("txn_req_addr", ifc.imem_req_addr, m_pc);
    for (int i = 0; i < d_req; i++) begin
      ifc.imem_req_ready = 1'b0;
      @(negedge clk);
      #1;
      chk1("txn_req_held", ifc.imem_req_valid, 1'b1);
      chk64("txn_addr_held", ifc.imem_req_addr, m_pc);
    end
    ifc.imem_req_ready = 1'b1;
    @(negedge clk);
    ifc.imem_req_ready = 1'b0;
    #1;
    chk1("txn_req_dropped", ifc.imem_req_valid, 1'b0);
    for (int i = 0; i < d_rsp; i++) begin
      @(negedge clk);
      #1;
      chk1("txn_wait_no_inst", ifc.inst_valid, 1'b0);
    end
    ifc.imem_rsp_valid = 1'b1;
    ifc.imem_rsp_data  = data;
    @(negedge clk);
    ifc.imem_rsp_valid = 1'b0;
    ifc.imem_rsp_data  = $urandom;
    #1;
    chk1("txn_inst_valid", ifc.inst_valid, 1'b1);
    chk32("txn_inst", ifc.inst, data);
    chk64("txn_inst_pc", ifc.inst_pc, m_pc);
    for (int i = 0; i < d_take; i++) begin
      @(negedge clk);
      #1;
      chk1("txn_inst_held", ifc.inst_valid, 1'b1);
      chk32("txn_inst_stable", ifc.inst, data);
    end
    ifc.inst_ready = 1'b1;
    @(negedge clk);
    ifc.inst_ready = 1'b0;
    #1;
    chk1("txn_inst_taken", ifc.inst_valid, 1'b0);
    for (int i = 0; i < d_com; i++) begin
      @(negedge clk);
      #1;
      chk1("txn_exec_no_req", ifc.imem_req_valid, 1'b0);
    end
    ifc.commit_valid = 1'b1;
    ifc.commit_dnpc  = dnpc;
    @(negedge clk);
    ifc.commit_valid = 1'b0;
    #1;
    m_retire = m_retire + 64'd1;
    m_pc     = dnpc;
    chk64("txn_retire", retire_cnt, m_retire);
    if (dnpc[1:0] == 2'b00) begin
      chk1("txn_next_req", ifc.imem_req_valid, 1'b1);
      chk64("txn_next_addr", ifc.imem_req_addr, m_pc);
      chk1("txn_no_fault", fetch_fault, 1'b0);
    end else begin
      chk1("txn_misalign_fault", fetch_fault, 1'b1);
      chk1("txn_misalign_no_req", ifc.imem_req_valid, 1'b0);
    end
  endtask

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        err;
    logic        irdy;
    logic        cv;
    logic [63:0] dnpc;
    logic        e_rv;
    logic [63:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [63:0] e_ipc;
    logic        e_flt;
    logic [63:0] e_ret;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  initial begin
    logic [63:0] d;
    int          t0;
    logic [63:0] r10;
    r10 = 64'h0000_0000_8000_0010;

    // rdy rv data err irdy cv dnpc | req_v addr inst_v inst inst_pc fault retire
    tbl[0]  = '{1, 0, 32'h0,        0, 0, 0, 64'h0,    1, RPC, 0, 32'h0,        RPC, 0, 0};
    tbl[1]  = '{0, 1, 32'h13,       0, 0, 0, 64'h0,    0, RPC, 0, 32'h0,        RPC, 0, 0};
    tbl[2]  = '{0, 0, 32'h0,        0, 0, 0, 64'h0,    0, RPC, 1, 32'h13,       RPC, 0, 0};
    tbl[3]  = '{0, 1, 32'h55,       0, 0, 1, 64'h40,   0, RPC, 1, 32'h13,       RPC, 0, 0};
    tbl[4]  = '{0, 0, 32'h0,        0, 0, 0, 64'h0,    0, RPC, 1, 32'h13,       RPC, 0, 0};
    tbl[5]  = '{0, 0, 32'h0,        0, 1, 0, 64'h0,    0, RPC, 1, 32'h13,       RPC, 0, 0};
    tbl[6]  = '{1, 1, 32'h66,       0, 1, 0, 64'h0,    0, RPC, 0, 32'h13,       RPC, 0, 0};
    tbl[7]  = '{0, 0, 32'h0,        0, 0, 1, r10,      0, RPC, 0, 32'h13,       RPC, 0, 0};
    tbl[8]  = '{0, 1, 32'h77,       0, 0, 1, 64'h99,   1, r10, 0, 32'h13,       RPC, 0, 1};
    tbl[9]  = '{0, 0, 32'h0,        0, 0, 0, 64'h0,    1, r10, 0, 32'h13,       RPC, 0, 1};
    tbl[10] = '{0, 0, 32'h0,        0, 0, 0, 64'h0,    1, r10, 0, 32'h13,       RPC, 0, 1};
    tbl[11] = '{0, 0, 32'h0,        0, 1, 0, 64'h0,    1, r10, 0, 32'h13,       RPC, 0, 1};
    tbl[12] = '{0, 0, 32'h0,        0, 0, 0, 64'h0,    1, r10, 0, 32'h13,       RPC, 0, 1};
    tbl[13] = '{1, 0, 32'h0,        0, 0, 0, 64'h0,    1, r10, 0, 32'h13,       RPC, 0, 1};
    tbl[14] = '{0, 0, 32'h0,        0, 0, 0, 64'h0,    0, r10, 0, 32'h13,       RPC, 0, 1};
    tbl[15] = '{0, 1, 32'hdeadbeef, 0, 0, 0, 64'h0,    0, r10, 0, 32'h13,       RPC, 0, 1};
    tbl[16] = '{0, 0, 32'h0,        0, 1, 1, 64'h123,  0, r10, 1, 32'hdeadbeef, r10, 0, 1};
    tbl[17] = '{0, 0, 32'h0,        0, 0, 1, 64'h0000_0000_8000_0006,
                                                       0, r10, 0, 32'hdeadbeef, r10, 0, 1};
    tbl[18] = '{1, 1, 32'h11,       0, 1, 1, 64'h0,    0, r10, 0, 32'hdeadbeef, r10, 1, 2};
    tbl[19] = '{0, 0, 32'h0,        0, 0, 0, 64'h0,    0, r10, 0, 32'hdeadbeef, r10, 1, 2};

    clear_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk1("reset_held_req_valid", ifc.imem_req_valid, 1'b0);
    chk1("reset_held_inst_valid", ifc.inst_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // directed cycle table: first fetch, handoff stall, ignored inputs, request stall, fault
    for (int i = 0; i < NV; i++) begin
      ifc.imem_req_ready = tbl[i].rdy;
      ifc.imem_rsp_valid = tbl[i].rv;
      ifc.imem_rsp_data  = tbl[i].rd;
      ifc.imem_rsp_err   = tbl[i].err;
      ifc.inst_ready     = tbl[i].irdy;
      ifc.commit_valid   = tbl[i].cv;
      ifc.commit_dnpc    = tbl[i].dnpc;
      #1;
      chk1($sformatf("tbl%0d_req_valid", i), ifc.imem_req_valid, tbl[i].e_rv);
      if (tbl[i].e_rv) chk64($sformatf("tbl%0d_req_addr", i), ifc.imem_req_addr, tbl[i].e_addr);
      chk1($sformatf("tbl%0d_inst_valid", i), ifc.inst_valid, tbl[i].e_iv);
      chk32($sformatf("tbl%0d_inst", i), ifc.inst, tbl[i].e_inst);
      chk64($sformatf("tbl%0d_inst_pc", i), ifc.inst_pc, tbl[i].e_ipc);
      chk1($sformatf("tbl%0d_fault", i), fetch_fault, tbl[i].e_flt);
      chk64($sformatf("tbl%0d_retire", i), retire_cnt, tbl[i].e_ret);
      @(negedge clk);
    end

    // reset recovers from FAULT
    do_reset("fault_clear");

    // random traffic against the PC-chain model
    for (int k = 0; k < 40; k++) begin
      d = {$urandom, $urandom};
      d[1:0] = 2'b00;
      run_one($urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0),
              $urandom_range(3, 0), d, $urandom);
    end
    d = {$urandom, $urandom};
    d[1:0] = 2'b10;
    run_one(1, 0, 2, 1, d, $urandom);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk1("misalign_sticky", fetch_fault, 1'b1);
    end

    // access fault on the response: no instruction is ever presented
    do_reset("err_pre");
    ifc.imem_req_ready = 1'b1;
    @(negedge clk);
    ifc.imem_req_ready = 1'b0;
    ifc.imem_rsp_valid = 1'b1;
    ifc.imem_rsp_err   = 1'b1;
    ifc.imem_rsp_data  = 32'h0000_0073;
    @(negedge clk);
    ifc.imem_rsp_valid = 1'b0;
    ifc.imem_rsp_err   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ifc.inst_ready   = 1'b1;
      ifc.imem_req_ready = 1'b1;
      #1;
      chk1("err_fault", fetch_fault, 1'b1);
      chk1("err_no_inst", ifc.inst_valid, 1'b0);
      chk1("err_no_req", ifc.imem_req_valid, 1'b0);
      @(negedge clk);
    end

    // reset while a request is outstanding in WAIT
    do_reset("wait_pre");
    for (int k = 0; k < 3; k++) run_one(0, 1, 0, 1, m_pc + 64'd8, $urandom);
    chk64("wait_pre_retire", retire_cnt, 64'd3);
    ifc.imem_req_ready = 1'b1;
    @(negedge clk);
    ifc.imem_req_ready = 1'b0;
    #1;
    chk1("wait_entered", ifc.imem_req_valid, 1'b0);
    do_reset("wait_rst");

    // back-to-back zero-wait traffic: 4 cycles per instruction
    t0 = cyc;
    for (int k = 0; k < 100; k++) run_one(0, 0, 0, 0, m_pc + 64'd4, $urandom);
    chk64("b2b_retire_100", retire_cnt, 64'd100);
    chk64("b2b_cycles", 64'(cyc - t0), 64'd400);
    chk64("b2b_final_addr", ifc.imem_req_addr, RPC + 64'd400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
